// File: rtl/nios2_jtag_debug_host.sv
// Host-side virtual-JTAG driver for the Nios II debug module: runs one IR-load/capture/shift/update
// sequence per command. Define NIOS2_JTAG_HOST_IR_CACHE_EN to skip UIR when the IR is unchanged.
module nios2_jtag_debug_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CNT_W = $clog2(DR_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_UIR  = 3'd1;
  localparam logic [2:0] S_CDR  = 3'd2;
  localparam logic [2:0] S_SDR  = 3'd3;
  localparam logic [2:0] S_UDR  = 3'd4;
  localparam logic [2:0] S_RTI  = 3'd5;
  localparam logic [2:0] S_RSP  = 3'd6;

  logic [2:0]          state;
  logic [DIV_W-1:0]    div_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DR_WIDTH-1:0] shift_reg;
  logic [IR_WIDTH-1:0] ir_reg;
  logic                tck_q;
  logic                tdi_q;
  logic                tck_active;
  logic                tck_rise;
  logic                tck_fall;
  logic                accept;
  logic                ir_hit;

  assign tck_active = (state != S_IDLE) && (state != S_RSP);
  assign tck_rise   = tck_active && (div_cnt == DIV_LAST) && !tck_q;
  assign tck_fall   = tck_active && (div_cnt == DIV_LAST) && tck_q;
  assign accept     = cmd_valid && cmd_ready;

`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
  logic [IR_WIDTH-1:0] last_ir;
  logic                ir_loaded;

  assign ir_hit = ir_loaded && (cmd_ir == last_ir);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ir   <= '0;
      ir_loaded <= 1'b0;
    end else if (accept) begin
      last_ir   <= cmd_ir;
      ir_loaded <= 1'b1;
    end
  end
`else
  assign ir_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      ir_reg     <= '0;
      tck_q      <= 1'b0;
      tdi_q      <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else if (state == S_IDLE) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
      if (accept) begin
        ir_reg    <= cmd_ir;
        shift_reg <= cmd_dr;
        bit_cnt   <= '0;
        state     <= ir_hit ? S_CDR : S_UIR;
      end
    end else if (state == S_RSP) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
      if (rsp_ready) state <= S_IDLE;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        tck_q   <= ~tck_q;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (tck_rise) begin
        if (state == S_UIR) rsp_ir_out <= vji_ir_out;
        if (state == S_SDR) shift_reg <= {vji_tdo, shift_reg[DR_WIDTH-1:1]};
      end

      // NOTE: tdi is registered on the falling edge rather than wired to shift_reg[0],
      // because the shift on the rising edge would otherwise move tdi while TCK is high.
      if (tck_fall) begin
        case (state)
          S_UIR: state <= S_CDR;
          S_CDR: begin
            state <= S_SDR;
            tdi_q <= shift_reg[0];
          end
          S_SDR: begin
            if (bit_cnt == BIT_LAST) begin
              state <= S_UDR;
              tdi_q <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tdi_q   <= shift_reg[0];
            end
          end
          S_UDR: state <= S_RTI;
          S_RTI: begin
            state  <= S_RSP;
            rsp_dr <= shift_reg;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Strobes decode directly from state, which only moves on accept or a TCK fall.
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RSP);
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = tck_active ? ir_reg : '0;
  assign vji_uir   = (state == S_UIR);
  assign vji_cdr   = (state == S_CDR);
  assign vji_sdr   = (state == S_SDR);
  assign vji_udr   = (state == S_UDR);
  assign vji_rti   = (state == S_RTI);

endmodule

// File: tb/tb_nios2_jtag_debug_host.sv
// Self-checking bench for nios2_jtag_debug_host: a TCK-clocked target DR model plus a response
// scoreboard; honours NIOS2_JTAG_HOST_IR_CACHE_EN when it is defined.
module tb_nios2_jtag_debug_host;

  localparam int DR  = 38;
  localparam int IR  = 2;
  localparam int DIV = 2;

  typedef struct {
    logic [DR-1:0] dr;
    logic [IR-1:0] ir_out;
    int            lat;
    bit            uir;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IR-1:0] cmd_ir = '0;
  logic [DR-1:0] cmd_dr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DR-1:0] rsp_dr;
  logic [IR-1:0] rsp_ir_out;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic [IR-1:0] vji_ir_in;
  logic [IR-1:0] ir_out_drv = '0;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  exp_t sb[$];

  // Reference model state
  logic [DR-1:0] m_tgt = '0;
  logic [IR-1:0] m_ir_out = '0;
  logic [IR-1:0] m_last_ir = '0;
  bit            m_loaded = 1'b0;

  // Target DR model: loads cap_value on a CDR rise when enabled, otherwise acts as a 38-stage delay line
  logic          cap_en = 1'b0;
  logic [DR-1:0] cap_value = '0;
  logic [DR-1:0] tgt_sr = '0;

  // Monitor state
  logic [4:0]    prev_s = '0;
  logic          prev_tck = 1'b0;
  logic          prev_tdi = 1'b0;
  logic [IR-1:0] mon_ir = '0;
  int            sdr_rises = 0;
  int            onehot_bad = 0;
  int            tdi_bad = 0;
  int            irin_bad = 0;
  logic [4:0]    seq[$];

  nios2_jtag_debug_host #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_dr     (cmd_dr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dr     (rsp_dr),
    .rsp_ir_out (rsp_ir_out),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (ir_out_drv),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vji_tdo = tgt_sr[0];

  always @(posedge vji_tck) begin
    if (vji_cdr && cap_en) tgt_sr <= cap_value;
    else if (vji_sdr)      tgt_sr <= {vji_tdi, tgt_sr[DR-1:1]};
  end

  always @(negedge clk) begin
    logic [4:0] s;
    s = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
    if ($countones(s) > 1) onehot_bad++;
    if (vji_tck && (vji_tdi !== prev_tdi)) tdi_bad++;
    if ((s != 5'b0) && (vji_ir_in !== mon_ir)) irin_bad++;
    if ((s != prev_s) && (s != 5'b0)) seq.push_back(s);
    if (vji_tck && !prev_tck && vji_sdr) sdr_rises++;
    prev_s   = s;
    prev_tck = vji_tck;
    prev_tdi = vji_tdi;
  end

  function automatic void push_exp(input logic [IR-1:0] ir, input logic [DR-1:0] dr);
    exp_t e;
    bit   hit;
    hit = 1'b0;
`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
    hit       = m_loaded && (ir == m_last_ir);
    m_loaded  = 1'b1;
    m_last_ir = ir;
`endif
    if (!hit) m_ir_out = ir_out_drv;
    e.ir_out = m_ir_out;
    e.dr     = cap_en ? cap_value : m_tgt;
    m_tgt    = dr;
    e.uir    = !hit;
    e.lat    = (DR + (hit ? 3 : 4)) * 2 * DIV;
    sb.push_back(e);
  endfunction

  task automatic mon_clear();
    sdr_rises  = 0;
    onehot_bad = 0;
    tdi_bad    = 0;
    irin_bad   = 0;
    seq.delete();
  endtask

  task automatic drive_cmd(input logic [IR-1:0] ir, input logic [DR-1:0] dr);
    for (int i = 0; i < 500; i++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    mon_clear();
    mon_ir    = ir;
    cmd_ir    = ir;
    cmd_dr    = dr;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    cmd_ir    = ~ir;
    cmd_dr    = ~dr;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if (rsp_valid) begin
        ok  = 1'b1;
        lat = cyc - acc_cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_dr !== '0) begin errors++; $display("FAIL reset_rsp_dr: got %h want 0", rsp_dr); end
    checks++; if (rsp_ir_out !== '0) begin errors++; $display("FAIL reset_rsp_ir_out: got %b want 0", rsp_ir_out); end
    checks++; if ({vji_tck, vji_tdi} !== 2'b00) begin errors++; $display("FAIL reset_tck_tdi: got %b want 00", {vji_tck, vji_tdi}); end
    checks++; if (vji_ir_in !== '0) begin errors++; $display("FAIL reset_ir_in: got %b want 0", vji_ir_in); end
    checks++; if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    bit   ok;
    logic [DR-1:0] dr_a, dr_b;
    dr_a = 38'h2A_5555_AAAA;
    dr_b = 38'h15_AAAA_5555;
    cap_en = 1'b0;
    ir_out_drv = 2'b01;
    push_exp(2'b01, dr_a);
    drive_cmd(2'b01, dr_a);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (sdr_rises != DR) begin errors++; $display("FAIL basic_sdr_rises: got %0d want %0d", sdr_rises, DR); end
    checks++; if (rsp_dr !== e.dr) begin errors++; $display("FAIL basic_rsp_dr: got %h want %h", rsp_dr, e.dr); end
    checks++; if (tgt_sr !== dr_a) begin errors++; $display("FAIL basic_tdi_stream: got %h want %h", tgt_sr, dr_a); end
    ack();
    // Second pass through the delay line returns the first command's data
    push_exp(2'b01, dr_b);
    drive_cmd(2'b01, dr_b);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL loop_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (rsp_dr !== e.dr) begin errors++; $display("FAIL loop_rsp_dr: got %h want %h", rsp_dr, e.dr); end
    checks++; if (rsp_ir_out !== e.ir_out) begin errors++; $display("FAIL loop_rsp_ir_out: got %b want %b", rsp_ir_out, e.ir_out); end
    ack();
  endtask

  task automatic test_capture();
    exp_t e;
    int   lat;
    bit   ok;
    cap_en = 1'b1;
    cap_value = 38'h3F_0000_0001;
    ir_out_drv = 2'b10;
    push_exp(2'b10, 38'h01_2345_6789);
    drive_cmd(2'b10, 38'h01_2345_6789);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL capture_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (rsp_dr !== e.dr) begin errors++; $display("FAIL capture_rsp_dr: got %h want %h", rsp_dr, e.dr); end
    checks++; if (rsp_ir_out !== e.ir_out) begin errors++; $display("FAIL capture_rsp_ir_out: got %b want %b", rsp_ir_out, e.ir_out); end
    ack();
  endtask

  task automatic test_sequencing();
    exp_t e;
    int   lat;
    bit   ok;
    logic [4:0] want[$];
    bit   seq_ok;
    cap_en = 1'b1;
    cap_value = 38'h0F_F00F_F00F;
    ir_out_drv = 2'b11;
    push_exp(2'b11, 38'h33_CCCC_3333);
    drive_cmd(2'b11, 38'h33_CCCC_3333);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    if (e.uir) want.push_back(5'b10000);
    want.push_back(5'b01000);
    want.push_back(5'b00100);
    want.push_back(5'b00010);
    want.push_back(5'b00001);
    seq_ok = (seq.size() == want.size());
    for (int i = 0; i < want.size() && seq_ok; i++) if (seq[i] !== want[i]) seq_ok = 1'b0;
    checks++; if (!seq_ok) begin
      errors++; $display("FAIL seq_order: got %0d states first %b want %0d states first %b", seq.size(), (seq.size() > 0) ? seq[0] : 5'b0, want.size(), want[0]);
    end
    checks++; if (onehot_bad != 0) begin errors++; $display("FAIL seq_onehot: got %0d overlaps want 0", onehot_bad); end
    checks++; if (tdi_bad != 0) begin errors++; $display("FAIL seq_tdi_stable: got %0d changes while tck high want 0", tdi_bad); end
    checks++; if (irin_bad != 0) begin errors++; $display("FAIL seq_ir_in: got %0d bad cycles want 0", irin_bad); end
    checks++; if (!ok || rsp_dr !== e.dr) begin errors++; $display("FAIL seq_rsp_dr: got %h want %h", rsp_dr, e.dr); end
    ack();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    bit   ok;
    int   bad_ready, bad_tck, bad_valid;
    logic [DR-1:0] dr_b;
    bad_ready = 0; bad_tck = 0; bad_valid = 0;
    dr_b = 38'h2B_1357_9BDF;
    cap_en = 1'b1;
    cap_value = 38'h00_1234_5678;
    ir_out_drv = 2'b01;
    push_exp(2'b01, 38'h0A_0A0A_0A0A);
    drive_cmd(2'b01, 38'h0A_0A0A_0A0A);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || rsp_dr !== e.dr) begin errors++; $display("FAIL bp_first_rsp_dr: got %h want %h", rsp_dr, e.dr); end
    // Second command waits on cmd_valid while the first response is stalled
    cap_value = 38'h25_DEAD_BEEF;
    ir_out_drv = 2'b10;
    push_exp(2'b10, dr_b);
    cmd_ir = 2'b10;
    cmd_dr = dr_b;
    cmd_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (cmd_ready !== 1'b0) bad_ready++;
      if (vji_tck !== 1'b0) bad_tck++;
      if (rsp_valid !== 1'b1) bad_valid++;
    end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL bp_cmd_ready: got %0d ready cycles want 0", bad_ready); end
    checks++; if (bad_tck != 0) begin errors++; $display("FAIL bp_tck_static: got %0d tck-high cycles want 0", bad_tck); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL bp_rsp_held: got %0d dropped cycles want 0", bad_valid); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL bp_handshake: got valid,ready=%b want 01", {rsp_valid, cmd_ready}); end
    mon_clear();
    mon_ir = 2'b10;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_dr = ~dr_b;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got ready=%b want 0", cmd_ready); end
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL bp_second_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (rsp_dr !== e.dr) begin errors++; $display("FAIL bp_second_rsp_dr: got %h want %h", rsp_dr, e.dr); end
    checks++; if (rsp_ir_out !== e.ir_out) begin errors++; $display("FAIL bp_second_ir_out: got %b want %b", rsp_ir_out, e.ir_out); end
    checks++; if (tgt_sr !== dr_b) begin errors++; $display("FAIL bp_second_tdi_stream: got %h want %h", tgt_sr, dr_b); end
    ack();
  endtask

  task automatic test_reset_mid_sdr();
    exp_t e;
    int   lat;
    bit   ok;
    int   stray;
    stray = 0;
    cap_en = 1'b1;
    cap_value = 38'h12_3456_789A;
    ir_out_drv = 2'b11;
    push_exp(2'b11, 38'h3C_3C3C_3C3C);
    drive_cmd(2'b11, 38'h3C_3C3C_3C3C);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (sdr_rises == 17) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach_bit17: got %0d rises want 17", sdr_rises); end
    reset = 1'b1;
    @(posedge clk); #1;
    void'(sb.pop_back());
    m_ir_out = '0;
    m_loaded = 1'b0;
    checks++; if ({cmd_ready, rsp_valid, vji_tck, vji_tdi} !== 4'b1000) begin
      errors++; $display("FAIL rst_ctrl: got %b want 1000", {cmd_ready, rsp_valid, vji_tck, vji_tdi});
    end
    checks++; if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in} !== 7'b0) begin
      errors++; $display("FAIL rst_strobes_ir: got %b want 0", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in});
    end
    checks++; if ({rsp_dr, rsp_ir_out} !== '0) begin errors++; $display("FAIL rst_rsp_regs: got %h/%b want 0", rsp_dr, rsp_ir_out); end
    reset = 1'b0;
    repeat (250) begin
      @(posedge clk); #1;
      if (rsp_valid) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_no_rsp: got %0d rsp_valid cycles want 0", stray); end
    cap_value = 38'h21_0FED_CBA9;
    ir_out_drv = 2'b10;
    push_exp(2'b01, 38'h1E_1E1E_1E1E);
    drive_cmd(2'b01, 38'h1E_1E1E_1E1E);
    wait_rsp(lat, ok);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL rst_fresh_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (rsp_dr !== e.dr) begin errors++; $display("FAIL rst_fresh_rsp_dr: got %h want %h", rsp_dr, e.dr); end
    checks++; if (rsp_ir_out !== e.ir_out) begin errors++; $display("FAIL rst_fresh_ir_out: got %b want %b", rsp_ir_out, e.ir_out); end
    ack();
  endtask

`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
  task automatic test_ir_cache();
    exp_t e;
    int   lat;
    bit   ok;
    bit   uir_seen;
    logic [IR-1:0] irs[3];
    logic [IR-1:0] drvs[3];
    irs  = '{2'b11, 2'b11, 2'b00};
    drvs = '{2'b01, 2'b10, 2'b11};
    cap_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cap_value = DR'($urandom) ^ (DR'($urandom) << 20);
      ir_out_drv = drvs[k];
      push_exp(irs[k], ~cap_value);
      drive_cmd(irs[k], ~cap_value);
      wait_rsp(lat, ok);
      e = sb.pop_front();
      uir_seen = 1'b0;
      foreach (seq[i]) if (seq[i] == 5'b10000) uir_seen = 1'b1;
      checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL cache_latency_%0d: got %0d want %0d", k, lat, e.lat); end
      checks++; if (uir_seen != e.uir) begin errors++; $display("FAIL cache_uir_%0d: got %b want %b", k, uir_seen, e.uir); end
      checks++; if (rsp_ir_out !== e.ir_out) begin errors++; $display("FAIL cache_ir_out_%0d: got %b want %b", k, rsp_ir_out, e.ir_out); end
      checks++; if (rsp_dr !== e.dr) begin errors++; $display("FAIL cache_rsp_dr_%0d: got %h want %h", k, rsp_dr, e.dr); end
      ack();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_capture();
    test_sequencing();
    test_backpressure();
    test_reset_mid_sdr();
`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
    test_ir_cache();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios2_jtag_debug_host.md
Name: nios2_jtag_debug_host

Overview:
- Host-side driver for the Nios II debug module's virtual-JTAG interface. Generates the TCK/TDI/IR and virtual-state strobes (uir, cdr, sdr, udr, rti) that the debug module's TCK/SYSCLK logic consumes, and collects TDO.
- Replaces the sld_virtual_jtag_basic PHY in simulation and in on-chip self-debug builds.
- Accepts one command at a time: a 2-bit IR plus a 38-bit DR. Performs a full IR-load / capture / shift / update sequence and returns the 38-bit captured DR.

Parameters:
- DR_WIDTH, 38: shift-register length; matches the debug module's sr/jdo width.
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: clk cycles per TCK half-period; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all logic rises on this edge.
- reset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle; command accepted when cmd_valid && cmd_ready.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_dr  out  DR_WIDTH  captured TDO bits; first bit shifted ends up in bit 0.
- rsp_ir_out  out  IR_WIDTH  vji_ir_out sampled during UIR.
- vji_tck  out  1  generated TCK.
- vji_tdi  out  1  serial data to target.
- vji_tdo  in  1  serial data from target.
- vji_ir_in  out  IR_WIDTH  IR presented to target.
- vji_ir_out  in  IR_WIDTH  IR status from target.
- vji_uir / vji_cdr / vji_sdr / vji_udr / vji_rti  out  1 each  virtual state strobes.

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0, all strobes=0.
  - Divider, bit counter and shift register cleared.
- TCK generation:
  - Runs only outside IDLE/RSP.
  - Divider counts 0..TCK_DIV-1; vji_tck toggles at each terminal count, giving period 2*TCK_DIV clk.
  - TCK starts low on command accept.
  - In IDLE/RSP, vji_tck is held 0 and the divider is held 0.
- Output update rule: state, strobes, vji_tdi and vji_ir_in change only on the clk edge where vji_tck goes high-to-low (or on accept). They are therefore stable around every TCK rising edge.
- TDO sampling: vji_tdo and vji_ir_out are sampled on the clk edge where vji_tck goes low-to-high.
- State machine, one TCK period per state unless noted:
  - IDLE: cmd_ready=1. On accept, latch cmd_ir/cmd_dr into ir_reg/shift register, then go to UIR.
  - UIR: vji_uir=1, vji_ir_in=ir_reg (held through RTI). At TCK rise, capture vji_ir_out into rsp_ir_out. Next state: CDR.
  - CDR: vji_cdr=1. Next state: SDR.
  - SDR: vji_sdr=1 for exactly DR_WIDTH TCK periods.
    - vji_tdi = shift register bit 0.
    - At each TCK rise: shift right and insert vji_tdo at bit DR_WIDTH-1.
    - Bit counter counts 0..DR_WIDTH-1; on the fall after the final bit, go to UDR.
  - UDR: vji_udr=1. Next state: RTI.
  - RTI: vji_rti=1. Then copy the shift register to rsp_dr, set rsp_valid=1, go to RSP.
  - RSP: TCK stopped, cmd_ready=0. On rsp_ready, rsp_valid falls next clk; return to IDLE.
- Strobe exclusivity: at most one strobe is high in any cycle.
- Latency: with TCK_DIV=2, DR_WIDTH=38, the sequence is 42 TCK periods = 168 clk from accept to rsp_valid.
- rsp_ready held high in RSP: one-cycle RSP, next command can be accepted the cycle after.
- cmd_valid while busy: ignored (cmd_ready=0); the command is not latched.
- Input changes after accept: cmd_ir/cmd_dr have no effect once latched.
- Reset mid-operation: all outputs return to reset values next clk. No rsp_valid is issued for the aborted command.
- rsp_dr / rsp_ir_out: hold their last values until the next transaction's RTI / UIR.

Optional Feature:
- Macro: NIOS2_JTAG_HOST_IR_CACHE_EN.
- Defined:
  - Block keeps last_ir and an ir_loaded flag; ir_loaded is cleared by reset.
  - On accept, if ir_loaded && cmd_ir==last_ir, UIR is skipped: CDR is entered directly and rsp_ir_out is unchanged.
  - Latency drops by one TCK period (164 clk at defaults).
- Undefined: every command performs UIR. last_ir/ir_loaded do not exist.

Test Plan:
- Basic transaction: reset; cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, vji_tdo looped to vji_tdi through a 38-stage TCK-clocked delay -> rsp_valid exactly 168 clk after accept; exactly 38 TCK rises with vji_sdr=1.
- Capture path: target model drives tdo with pattern 38'h3F_0000_0001 LSB first -> rsp_dr=38'h3F_0000_0001; vji_ir_out=2'b10 during UIR -> rsp_ir_out=2'b10.
- Sequencing: one command -> strobes appear in order uir, cdr, sdr(x38), udr, rti, each one-hot; vji_ir_in=cmd_ir from UIR through RTI; vji_tdi never changes while vji_tck=1.
- Backpressure: rsp_ready=0 for 20 clk and cmd_valid=1 throughout -> cmd_ready=0, vji_tck static 0; the second command is accepted only after the rsp handshake.
- Reset mid-SDR: assert reset at bit 17 -> next clk all outputs at reset values; no rsp_valid; a fresh command then completes normally.
- IR cache (macro defined): two commands with ir=2'b11 -> the second has no vji_uir pulse and a latency of 164 clk. A third command with ir=2'b00 -> vji_uir present.
